// File: rtl/pl_uart_tx.sv
// pl_uart_tx: memory-mapped UART transmitter for the GPIO region (selected by HSEL).
// The CPU stores bytes into a TX FIFO. A bit-timed FSM serialises each byte as 8N1 on UART_TX.
// A level interrupt reports when the FIFO has drained and the line is idle.
// Optional build macro UART_TX_PARITY_EN adds a parity bit after the data bits (8E1, or 8O1 via CTRL[1]).
module pl_uart_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        HSEL,
   input  logic        we,
   input  logic [5:0]  haddr,
   input  logic [31:0] datain,
   output logic [31:0] dataout,
   output logic        irq,
   output logic        UART_TX
);

   localparam int          AW        = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_CNT = FIFO_DEPTH[AW:0];

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t        state;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [8:0]    count_ext;
   logic [7:0]    shreg;
   logic [2:0]    bit_idx;
   logic [15:0]   bit_timer;
   logic [15:0]   div_latched;
   logic [15:0]   bauddiv;
   logic [15:0]   eff_div;
   logic          ovf;
   logic          irq_en;
   logic          par_odd_rd;
   logic          empty;
   logic          full;
   logic          busy;
   logic          tick;
   logic          push_req;
   logic          push_ok;
   logic          pop;
   logic          wr_status;
   logic          wr_ctrl;
   logic          wr_baud;
   logic          unused_bits;

`ifdef UART_TX_PARITY_EN
   logic          par_odd;
   assign par_odd_rd = par_odd;
`else
   assign par_odd_rd = 1'b0;
`endif

   assign push_req  = HSEL && we && (haddr == 6'd0);
   assign wr_status = HSEL && we && (haddr == 6'd1);
   assign wr_ctrl   = HSEL && we && (haddr == 6'd2);
   assign wr_baud   = HSEL && we && (haddr == 6'd3);

   assign empty     = (count == '0);
   assign full      = (count == DEPTH_CNT);
   assign busy      = (state != S_IDLE);
   assign tick      = (bit_timer == 16'd0);
   assign eff_div   = (bauddiv < 16'd2) ? 16'd2 : bauddiv;
   assign pop       = !empty && ((state == S_IDLE) || ((state == S_STOP) && tick));
   assign push_ok   = push_req && (!full || pop);
   assign count_ext = 9'(count);
   assign unused_bits = ^{datain[31:16], count_ext[8]};

   // FIFO storage needs no reset; only the pointers and count define its contents.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= datain[7:0];
   end

   // FIFO pointers and occupancy; a push into a full FIFO is accepted only when a pop frees a slot.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         if (push_ok && !pop)      count <= count + (AW+1)'(1);
         else if (!push_ok && pop) count <= count - (AW+1)'(1);
      end
   end

   // Control registers and the sticky overflow flag.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         ovf     <= 1'b0;
         irq_en  <= 1'b0;
         bauddiv <= 16'(CLKS_PER_BIT);
`ifdef UART_TX_PARITY_EN
         par_odd <= 1'b0;
`endif
      end else begin
         if (wr_status && datain[3])   ovf <= 1'b0;
         else if (push_req && !push_ok) ovf <= 1'b1;
         if (wr_ctrl) begin
            irq_en  <= datain[0];
`ifdef UART_TX_PARITY_EN
            par_odd <= datain[1];
`endif
         end
         if (wr_baud) bauddiv <= datain[15:0];
      end
   end

   // Frame sequencer: start bit, 8 data bits LSB first, optional parity, stop; back-to-back when FIFO holds more.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state       <= S_IDLE;
         UART_TX     <= 1'b1;
         shreg       <= 8'd0;
         bit_idx     <= 3'd0;
         bit_timer   <= 16'd0;
         div_latched <= 16'd2;
      end else begin
         case (state)
            S_IDLE: begin
               if (!empty) begin
                  shreg       <= mem[rd_ptr];
                  div_latched <= eff_div;
                  bit_timer   <= eff_div - 16'd1;
                  UART_TX     <= 1'b0;
                  state       <= S_START;
               end
            end
            S_START: begin
               if (tick) begin
                  bit_timer <= div_latched - 16'd1;
                  bit_idx   <= 3'd0;
                  UART_TX   <= shreg[0];
                  state     <= S_DATA;
               end else begin
                  bit_timer <= bit_timer - 16'd1;
               end
            end
            S_DATA: begin
               if (tick) begin
                  bit_timer <= div_latched - 16'd1;
                  if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     UART_TX <= (^shreg) ^ par_odd;
                     state   <= S_PARITY;
`else
                     UART_TX <= 1'b1;
                     state   <= S_STOP;
`endif
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     UART_TX <= shreg[bit_idx + 3'd1];
                  end
               end else begin
                  bit_timer <= bit_timer - 16'd1;
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (tick) begin
                  bit_timer <= div_latched - 16'd1;
                  UART_TX   <= 1'b1;
                  state     <= S_STOP;
               end else begin
                  bit_timer <= bit_timer - 16'd1;
               end
            end
`endif
            S_STOP: begin
               if (tick) begin
                  if (!empty) begin
                     shreg       <= mem[rd_ptr];
                     div_latched <= eff_div;
                     bit_timer   <= eff_div - 16'd1;
                     UART_TX     <= 1'b0;
                     state       <= S_START;
                  end else begin
                     state <= S_IDLE;
                  end
               end else begin
                  bit_timer <= bit_timer - 16'd1;
               end
            end
            default: begin
               state   <= S_IDLE;
               UART_TX <= 1'b1;
            end
         endcase
      end
   end

   // Drain interrupt, registered so it follows the idle/empty condition by one cycle.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) irq <= 1'b0;
      else     irq <= irq_en & empty & ~busy;
   end

   // Register read mux; STATUS reflects the registered state, so a same-cycle push is not yet visible.
   always_comb begin
      dataout = 32'd0;
      if (HSEL) begin
         case (haddr)
            6'd1:    dataout = {16'd0, count_ext[7:0], 4'd0, ovf, empty, full, busy};
            6'd2:    dataout = {30'd0, par_odd_rd, irq_en};
            6'd3:    dataout = {16'd0, bauddiv};
            default: dataout = 32'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_pl_uart_tx.sv
// tb_pl_uart_tx: scoreboard bench for pl_uart_tx. Accepted bytes are queued as expected frames;
// a line monitor decodes every frame on UART_TX and compares it against the queue.
module tb_pl_uart_tx;

   localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif

   logic        clk = 1'b0;
   logic        clr;
   logic        HSEL;
   logic        we;
   logic [5:0]  haddr;
   logic [31:0] datain;
   logic [31:0] dataout;
   logic        irq;
   logic        UART_TX;

   typedef struct {
      logic [7:0] data;
      int         div;
      logic       odd;
   } frame_t;

   frame_t frame_q[$];
   int     compared   = 0;
   int     mismatched = 0;
   int     shadow_div = 868;
   logic   shadow_odd = 1'b0;
   bit     mon_busy   = 1'b0;

   pl_uart_tx #(.CLKS_PER_BIT(868), .FIFO_DEPTH(DEPTH)) dut (
      .clk     (clk),
      .clr     (clr),
      .HSEL    (HSEL),
      .we      (we),
      .haddr   (haddr),
      .datain  (datain),
      .dataout (dataout),
      .irq     (irq),
      .UART_TX (UART_TX)
   );

   // 10-unit system clock.
   always #5 clk = ~clk;

   // One comparison: counts it, and reports a FAIL line on disagreement.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Bus write issued at a falling edge, captured by the following rising edge.
   task automatic applyStimulus(input logic [5:0] addr, input logic [31:0] data);
      if (addr == 6'd3) shadow_div = int'(data[15:0]);
      if (addr == 6'd2) shadow_odd = data[1];
      HSEL = 1'b1; we = 1'b1; haddr = addr; datain = data;
      @(negedge clk);
      HSEL = 1'b0; we = 1'b0; haddr = 6'd0; datain = 32'd0;
   endtask

   // Combinational bus read between clock edges.
   task automatic busRead(input logic [5:0] addr, output logic [31:0] data);
      HSEL = 1'b1; we = 1'b0; haddr = addr;
      #1 data = dataout;
      HSEL = 1'b0; haddr = 6'd0;
   endtask

   // Push a byte; when it is expected to be accepted, its frame joins the scoreboard.
   task automatic pushByte(input logic [7:0] b, input bit accept);
      frame_t f;
      if (accept) begin
         f.data = b;
         f.div  = (shadow_div < 2) ? 2 : shadow_div;
         f.odd  = shadow_odd;
         frame_q.push_back(f);
      end
      applyStimulus(6'd0, {24'd0, b});
   endtask

   // Count consecutive busy cycles starting from the current falling edge.
   task automatic measureBusy(output int cycles);
      logic [31:0] st;
      cycles = 0;
      for (int i = 0; i < 4000; i++) begin
         busRead(6'd1, st);
         if (st[0]) cycles++;
         else if (cycles > 0) break;
         @(negedge clk);
      end
   endtask

   // Bounded wait until the DUT is idle and every expected frame has been seen.
   task automatic waitIdle();
      logic [31:0] st;
      bit done;
      done = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         busRead(6'd1, st);
         if (st[2:0] == 3'b100 && !mon_busy && frame_q.size() == 0) begin
            done = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checkOutput("wait_idle", {31'd0, done}, 32'd1);
   endtask

   // Expected line level for bit slot idx of a frame.
   function automatic logic expectedBit(input frame_t f, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return f.data[idx-1];
`ifdef UART_TX_PARITY_EN
      if (idx == 9) return (^f.data) ^ f.odd;
`endif
      return 1'b1;
   endfunction

   // Line monitor: detects a start bit, checks every sample of the frame and decodes the byte mid-bit.
   initial begin : monitor
      frame_t     f;
      int         errs;
      int         slot;
      logic [7:0] got;
      bit         aborted;
      forever begin
         @(negedge clk);
         if (!clr && UART_TX === 1'b0) begin
            if (frame_q.size() == 0) begin
               checkOutput("unexpected_frame", 32'd1, 32'd0);
               while (UART_TX !== 1'b1) @(negedge clk);
            end else begin
               mon_busy = 1'b1;
               f        = frame_q.pop_front();
               errs     = 0;
               got      = 8'd0;
               aborted  = 1'b0;
               for (int s = 0; s < FRAME_BITS * f.div; s++) begin
                  if (s > 0) @(negedge clk);
                  if (clr) begin
                     aborted = 1'b1;
                     break;
                  end
                  slot = s / f.div;
                  if (UART_TX !== expectedBit(f, slot)) errs++;
                  if ((s % f.div) == (f.div / 2) && slot >= 1 && slot <= 8) got[slot-1] = UART_TX;
               end
               if (!aborted) begin
                  checkOutput("frame_data", {24'd0, got}, {24'd0, f.data});
                  checkOutput("frame_shape_errors", errs, 32'd0);
               end
               mon_busy = 1'b0;
            end
         end
      end
   end

   // Directed scenarios followed by randomized bursts.
   initial begin : stimulus
      logic [31:0] st;
      int          cycles;
      int          n;
      int          d;
      HSEL = 1'b0; we = 1'b0; haddr = 6'd0; datain = 32'd0;
      clr  = 1'b1;
      repeat (3) @(negedge clk);
      clr = 1'b0;
      @(negedge clk);

      // Reset state.
      busRead(6'd1, st);  checkOutput("reset_status", st, 32'h0000_0004);
      checkOutput("reset_tx", {31'd0, UART_TX}, 32'd1);
      checkOutput("reset_irq", {31'd0, irq}, 32'd0);
      busRead(6'd3, st);  checkOutput("reset_bauddiv", st, 32'd868);
      busRead(6'd2, st);  checkOutput("reset_ctrl", st, 32'd0);
      busRead(6'd9, st);  checkOutput("unmapped_read", st, 32'd0);
      checkOutput("hsel_low_read", dataout, 32'd0);

      // Single frame 0xA5 at BAUDDIV=4: latency and frame length.
      applyStimulus(6'd3, 32'd4);
      busRead(6'd3, st);  checkOutput("bauddiv_readback", st, 32'd4);
      pushByte(8'hA5, 1'b1);
      checkOutput("tx_high_at_write", {31'd0, UART_TX}, 32'd1);
      @(negedge clk);
      checkOutput("tx_low_after_pop", {31'd0, UART_TX}, 32'd0);
      measureBusy(cycles);
      checkOutput("busy_cycles_single", cycles, FRAME_BITS * 4);
      waitIdle();

      // Fill: nine back-to-back writes are accepted, the tenth overflows.
      for (int i = 0; i < 9; i++) pushByte(8'($urandom), 1'b1);
      busRead(6'd1, st);  checkOutput("status_full", st, 32'h0000_0803);
      pushByte(8'hEE, 1'b0);
      busRead(6'd1, st);  checkOutput("status_ovf", st, 32'h0000_080B);
      // Busy began one cycle after the first write; 8 of the contiguous 9 frames' cycles already elapsed.
      measureBusy(cycles);
      checkOutput("busy_cycles_contiguous", cycles, 9 * FRAME_BITS * 4 - 8);
      waitIdle();
      busRead(6'd1, st);  checkOutput("status_ovf_idle", st, 32'h0000_000C);
      applyStimulus(6'd1, 32'h0000_0008);
      busRead(6'd1, st);  checkOutput("status_ovf_cleared", st, 32'h0000_0004);

      // Drain interrupt.
      applyStimulus(6'd2, 32'd1);
      repeat (2) @(negedge clk);
      checkOutput("irq_idle_enabled", {31'd0, irq}, 32'd1);
      pushByte(8'h3C, 1'b1);
      checkOutput("irq_write_cycle", {31'd0, irq}, 32'd1);
      @(negedge clk);
      checkOutput("irq_dropped_by_push", {31'd0, irq}, 32'd0);
      repeat (FRAME_BITS * 4) @(negedge clk);
      checkOutput("irq_at_stop_end", {31'd0, irq}, 32'd0);
      @(negedge clk);
      checkOutput("irq_after_stop", {31'd0, irq}, 32'd1);
      applyStimulus(6'd2, 32'd0);
      waitIdle();

      // Reset mid-DATA with further bytes queued.
      pushByte(8'h00, 1'b1);
      pushByte(8'h55, 1'b1);
      pushByte(8'h33, 1'b1);
      repeat (15) @(negedge clk);
      checkOutput("tx_low_mid_data", {31'd0, UART_TX}, 32'd0);
      clr = 1'b1;
      #1 checkOutput("tx_high_on_reset", {31'd0, UART_TX}, 32'd1);
      repeat (3) @(negedge clk);
      clr = 1'b0;
      frame_q.delete();
      shadow_div = 868;
      shadow_odd = 1'b0;
      @(negedge clk);
      busRead(6'd1, st);  checkOutput("status_after_reset", st, 32'h0000_0004);
      applyStimulus(6'd3, 32'd4);

`ifdef UART_TX_PARITY_EN
      // Parity frames: even then odd for 0x07.
      busRead(6'd2, st);  checkOutput("ctrl_par_odd_reset", st, 32'd0);
      pushByte(8'h07, 1'b1);
      @(negedge clk);
      measureBusy(cycles);
      checkOutput("busy_cycles_parity", cycles, 44);
      waitIdle();
      applyStimulus(6'd2, 32'd2);
      busRead(6'd2, st);  checkOutput("ctrl_par_odd_set", st, 32'd2);
      pushByte(8'h07, 1'b1);
      waitIdle();
      applyStimulus(6'd2, 32'd0);
`endif

      // Randomized bursts with random divisors (0 and 1 behave as 2).
      for (int r = 0; r < 6; r++) begin
         d = int'($urandom_range(0, 6));
         applyStimulus(6'd3, 32'(d));
         applyStimulus(6'd2, {30'd0, 1'($urandom_range(0, 1)), 1'b0});
         n = int'($urandom_range(1, DEPTH));
         for (int i = 0; i < n; i++) pushByte(8'($urandom), 1'b1);
         waitIdle();
      end

      checkOutput("frames_outstanding", frame_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
